// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, resolve-side update, flush control and statistics bundle
// shared by the branch predictor and whoever drives it.
interface branch_predictor_if;
    logic        pred_en;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_is_branch;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    logic        clear_req;
    logic        busy;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    modport master (
        output pred_en, pred_pc,
        input  pred_hit, pred_taken, pred_target,
        output upd_valid, upd_pc, upd_target, upd_is_branch, upd_taken,
        output upd_pred_taken, upd_pred_target,
        input  mispredict, redirect_pc,
        output clear_req,
        input  busy, stat_lookups, stat_mispredicts
    );

    modport slave (
        input  pred_en, pred_pc,
        output pred_hit, pred_taken, pred_target,
        input  upd_valid, upd_pc, upd_target, upd_is_branch, upd_taken,
        input  upd_pred_taken, upd_pred_target,
        output mispredict, redirect_pc,
        input  clear_req,
        output busy, stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch target buffer with saturating direction counters,
// a one-entry-per-cycle flush sweep and saturating lookup/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp_io
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [31:0] stat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    logic             valid_q  [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;
    logic [31:0]      lookups_q;
    logic [31:0]      mispred_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_en;
    logic             up_hit;
    logic             mispred;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_valid_d;
    logic [CNT_W-1:0] wr_cnt_d;
    logic             wr_meta_en;

    // Lookup path: purely combinational, sees the table as it was before this edge.
    assign lk_idx   = bp_io.pred_pc[IDX_W+1:2];
    assign lk_tag   = bp_io.pred_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy_q;
    assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

    assign bp_io.pred_hit    = lk_hit;
    assign bp_io.pred_taken  = lk_taken;
    assign bp_io.pred_target = lk_taken ? target_q[lk_idx] : bp_io.pred_pc + 32'd4;

    assign up_idx  = bp_io.upd_pc[IDX_W+1:2];
    assign up_tag  = bp_io.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_en   = bp_io.upd_valid && !busy_q;
    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign mispred = up_en &&
                     ((bp_io.upd_pred_taken != bp_io.upd_taken) ||
                      (bp_io.upd_taken && (bp_io.upd_pred_target != bp_io.upd_target)));

    assign bp_io.mispredict       = mispred;
    assign bp_io.redirect_pc      = bp_io.upd_taken ? bp_io.upd_target : bp_io.upd_pc + 32'd4;
    assign bp_io.busy             = busy_q;
    assign bp_io.stat_lookups     = lookups_q;
    assign bp_io.stat_mispredicts = mispred_q;

    // At most one entry changes per cycle: the sweep slot while flushing, else the resolved one.
    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = up_idx;
        wr_valid_d = valid_q[up_idx];
        wr_cnt_d   = cnt_q[up_idx];
        wr_meta_en = 1'b0;
        if (busy_q) begin
            wr_en      = 1'b1;
            wr_idx     = ptr_q;
            wr_valid_d = 1'b0;
            wr_cnt_d   = CNT_WEAK_NT;
        end else if (up_en) begin
            if (up_hit && bp_io.upd_is_branch) begin
                wr_en      = 1'b1;
                wr_cnt_d   = bp_io.upd_taken ? cnt_inc(cnt_q[up_idx]) : cnt_dec(cnt_q[up_idx]);
                wr_meta_en = bp_io.upd_taken;
            end else if (up_hit) begin
                wr_en      = 1'b1;
                wr_valid_d = 1'b0;
            end else if (bp_io.upd_is_branch && bp_io.upd_taken) begin
                wr_en      = 1'b1;
                wr_valid_d = 1'b1;
                wr_cnt_d   = CNT_WEAK_T;
                wr_meta_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WEAK_NT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid_d;
            cnt_q[wr_idx]   <= wr_cnt_d;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_meta_en) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bp_io.upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bp_io.clear_req) begin
                        state_q   <= ST_CLEAR;
                        ptr_q     <= '0;
                        busy_q    <= 1'b1;
                        lookups_q <= '0;
                        mispred_q <= '0;
                    end else begin
                        lookups_q <= stat_inc(lookups_q, bp_io.pred_en);
                        mispred_q <= stat_inc(mispred_q, mispred);
                    end
                end
                ST_CLEAR: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor with a queue-based scoreboard
// fed by an abstract table model.
module tb_branch_predictor;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp();

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .TAG_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .bp_io (bp.slave)
    );

    typedef struct {
        bit        hit;
        bit        taken;
        bit [31:0] ptgt;
        bit        misp;
        bit [31:0] redir;
        bit        busy;
        bit [31:0] lk;
        bit [31:0] mp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Behavioural model of the table and statistics.
    bit        m_valid[N];
    bit [7:0]  m_tag[N];
    bit [31:0] m_tgt[N];
    int        m_cnt[N];
    int        m_clr_left;
    bit [31:0] m_lk, m_mp;

    // Stimulus for the next cycle.
    bit        s_rst, s_pe, s_uv, s_isb, s_ut, s_upt, s_clr;
    bit [31:0] s_pc, s_upc, s_utgt, s_uptgt;

    function automatic int idx_of(bit [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit [7:0] tag_of(bit [31:0] pc);
        return 8'((pc >> 6) % 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_clr_left = 0;
        m_lk = 0;
        m_mp = 0;
    endtask

    task automatic chk(string name, bit [31:0] act, bit [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, want, $time);
    endtask

    task automatic step();
        exp_t e;
        int li, ui, k;
        bit uh;
        @(posedge clk);
        #1;
        rst                 = s_rst;
        bp.pred_en          = s_pe;
        bp.pred_pc          = s_pc;
        bp.upd_valid        = s_uv;
        bp.upd_pc           = s_upc;
        bp.upd_target       = s_utgt;
        bp.upd_is_branch    = s_isb;
        bp.upd_taken        = s_ut;
        bp.upd_pred_taken   = s_upt;
        bp.upd_pred_target  = s_uptgt;
        bp.clear_req        = s_clr;
        if (s_rst) model_reset();

        e.busy  = (m_clr_left > 0);
        li      = idx_of(s_pc);
        e.hit   = !e.busy && m_valid[li] && (m_tag[li] == tag_of(s_pc));
        e.taken = e.hit && (m_cnt[li] >= 2);
        e.ptgt  = e.taken ? m_tgt[li] : s_pc + 32'd4;
        e.misp  = s_uv && !e.busy && ((s_upt != s_ut) || (s_ut && s_uptgt != s_utgt));
        e.redir = s_ut ? s_utgt : s_upc + 32'd4;
        e.lk    = m_lk;
        e.mp    = m_mp;
        exp_q.push_back(e);

        if (!s_rst) begin
            if (e.busy) begin
                k = N - m_clr_left;
                m_valid[k] = 0;
                m_cnt[k]   = 1;
                m_clr_left--;
            end else begin
                if (s_pe && m_lk != 32'hFFFF_FFFF) m_lk++;
                if (e.misp && m_mp != 32'hFFFF_FFFF) m_mp++;
                if (s_uv) begin
                    ui = idx_of(s_upc);
                    uh = m_valid[ui] && (m_tag[ui] == tag_of(s_upc));
                    if (uh && s_isb) begin
                        if (s_ut) begin
                            m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
                            m_tgt[ui] = s_utgt;
                        end else begin
                            m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
                        end
                    end else if (uh) begin
                        m_valid[ui] = 0;
                    end else if (s_isb && s_ut) begin
                        m_valid[ui] = 1;
                        m_tag[ui]   = tag_of(s_upc);
                        m_tgt[ui]   = s_utgt;
                        m_cnt[ui]   = 2;
                    end
                end
                if (s_clr) begin
                    m_clr_left = N;
                    m_lk = 0;
                    m_mp = 0;
                end
            end
        end
    endtask

    task automatic quiet();
        s_rst = 0; s_pe = 0; s_uv = 0; s_isb = 0; s_ut = 0; s_upt = 0; s_clr = 0;
        s_upc = 0; s_utgt = 0; s_uptgt = 0;
    endtask

    task automatic upd(bit [31:0] pc, bit isb, bit t, bit [31:0] tgt);
        s_uv = 1; s_upc = pc; s_isb = isb; s_ut = t; s_utgt = tgt;
        s_upt = t; s_uptgt = tgt;
    endtask

    function automatic bit [31:0] rand_pc();
        bit [31:0] pc;
        pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc | ($urandom & 32'hFFFF_C003);
        return pc;
    endfunction

    // Monitor: outputs are compared half a cycle after the inputs change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pred_hit",    32'(bp.pred_hit),   32'(e.hit));
                chk("pred_taken",  32'(bp.pred_taken), 32'(e.taken));
                chk("pred_target", bp.pred_target,     e.ptgt);
                chk("mispredict",  32'(bp.mispredict), 32'(e.misp));
                chk("redirect_pc", bp.redirect_pc,     e.redir);
                chk("busy",        32'(bp.busy),       32'(e.busy));
                chk("stat_lookups",     bp.stat_lookups,     e.lk);
                chk("stat_mispredicts", bp.stat_mispredicts, e.mp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bp.pred_en = 0; bp.pred_pc = 0; bp.upd_valid = 0; bp.upd_pc = 0;
        bp.upd_target = 0; bp.upd_is_branch = 0; bp.upd_taken = 0;
        bp.upd_pred_taken = 0; bp.upd_pred_target = 0; bp.clear_req = 0;
        model_reset();
        quiet();
        s_pc = 32'h40;
        s_rst = 1;
        repeat (3) step();
        s_rst = 0;

        // Miss, allocate with a same-cycle lookup, then hit.
        s_pe = 1; s_pc = 32'h40;
        upd(32'h40, 1, 1, 32'h100);
        step();
        quiet(); s_pe = 1;
        step();

        // Counter saturation walk on entry 0x40.
        for (int i = 0; i < 3; i++) begin
            quiet(); s_pe = 1; upd(32'h40, 1, 0, 32'h0); step();
        end
        for (int i = 0; i < 4; i++) begin
            quiet(); s_pe = 1; upd(32'h40, 1, 1, 32'h100); step();
        end
        for (int i = 0; i < 2; i++) begin
            quiet(); s_pe = 1; upd(32'h40, 1, 0, 32'h0); step();
        end
        quiet(); s_pe = 1; step();

        // Tag alias on index 0 replaces the old entry.
        quiet(); s_pe = 1; s_pc = 32'h440; step();
        quiet(); s_pe = 1; s_pc = 32'h440; upd(32'h440, 1, 1, 32'h200); step();
        quiet(); s_pe = 1; s_pc = 32'h40; step();
        quiet(); s_pe = 1; s_pc = 32'h440; step();

        // Non-branch hit invalidates the entry.
        quiet(); s_pc = 32'h440; upd(32'h440, 0, 0, 32'h0); step();
        quiet(); s_pc = 32'h440; step();

        // Mispredicts: direction wrong both ways, and target wrong.
        quiet(); upd(32'h80, 1, 1, 32'h300); s_upt = 0; step();
        quiet(); upd(32'h80, 1, 0, 32'h300); s_upt = 1; step();
        quiet(); upd(32'h80, 1, 1, 32'h300); s_uptgt = 32'h304; step();
        quiet(); step();

        // Flush sweep with an ignored second request.
        quiet(); upd(32'h0, 1, 1, 32'h500); step();
        quiet(); upd(32'h4, 1, 1, 32'h504); step();
        quiet(); upd(32'h8, 1, 1, 32'h508); step();
        quiet(); s_pe = 1; s_pc = 32'h4; s_clr = 1; step();
        for (int i = 0; i < N + 2; i++) begin
            quiet(); s_pe = 1; s_pc = 32'(4 * (i % 3));
            s_clr = (i == 3);
            if (i == 5) upd(32'h8, 1, 1, 32'h600);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            quiet(); s_pe = 1; s_pc = 32'(4 * i); step();
        end

        // Reset in the fifth sweep cycle ends the flush at once.
        quiet(); upd(32'hC, 1, 1, 32'h700); step();
        quiet(); s_clr = 1; step();
        for (int i = 0; i < 4; i++) begin
            quiet(); s_pe = 1; s_pc = 32'hC; step();
        end
        quiet(); s_rst = 1; s_pe = 1; s_pc = 32'hC; upd(32'h80, 1, 1, 32'h300); s_upt = 0; step();
        quiet(); s_pe = 1; s_pc = 32'hC; step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            quiet();
            s_pe    = 1'($urandom_range(0, 1));
            s_pc    = rand_pc();
            s_uv    = ($urandom_range(0, 3) != 0);
            s_upc   = rand_pc();
            s_isb   = ($urandom_range(0, 7) != 0);
            s_ut    = 1'($urandom_range(0, 1));
            s_utgt  = ($urandom_range(0, 3) == 0) ? $urandom : 32'(32'h100 * $urandom_range(1, 3));
            s_upt   = 1'($urandom_range(0, 1));
            s_uptgt = ($urandom_range(0, 1) == 0) ? s_utgt : 32'(32'h100 * $urandom_range(1, 3));
            s_clr   = ($urandom_range(0, 99) == 0);
            s_rst   = ($urandom_range(0, 499) == 0);
            step();
        end

        quiet();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
